router_data_reg: RTL and testbench

- Datapath register stage of the 1x3 router, directly downstream of the router FSM controller.
- Consumes the FSM state strobes and the serial packet byte stream, and presents the registered byte `dout` to the output FIFOs.
- Holds the header byte and holds a byte that arrives while the FIFO is full.
- Computes running parity, flags parity errors, and returns `parity_done`/`low_pkt_valid` to the FSM.

---
 rtl/router_data_reg.sv | 165 ++++++++++++++++
 tb/tb_router_data_reg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_data_reg.sv
// rtl/router_data_reg.sv - 1x3 router datapath register stage: header/full-byte hold, running parity, error flag.
// Optional saturating error counter enabled by defining ROUTER_REG_ERR_CNT_EN.
module router_data_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  full_state,
  input  logic                  laf_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] full_q, full_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic                  parity_done_q, parity_done_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  err_q, err_d;
  logic                  full_state_unused;

  // FIFO_FULL_STATE only waits for space; no register changes there.
  assign full_state_unused = full_state;

  // Address 3 is not a valid destination, so its header never replaces the stored one.
  always_comb begin
    header_d = header_q;
    if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
      header_d = data_in;
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (lfd_state) begin
      dout_d = header_q;
    end else if (ld_state && !fifo_full) begin
      dout_d = data_in;
    end else if (laf_state) begin
      dout_d = full_q;
    end
  end

  always_comb begin
    full_d = full_q;
    if (ld_state && fifo_full) begin
      full_d = data_in;
    end
  end

  // A byte held in full_byte is folded in when accepted, not again when replayed.
  always_comb begin
    int_par_d = int_par_q;
    if (detect_add) begin
      int_par_d = '0;
    end else if (lfd_state) begin
      int_par_d = int_par_q ^ header_q;
    end else if (ld_state && pkt_valid) begin
      int_par_d = int_par_q ^ data_in;
    end
  end

  always_comb begin
    pkt_par_d = pkt_par_q;
    if (detect_add) begin
      pkt_par_d = '0;
    end else if (ld_state && !pkt_valid) begin
      pkt_par_d = data_in;
    end
  end

  always_comb begin
    parity_done_d = parity_done_q;
    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if (ld_state && !fifo_full && !pkt_valid) begin
      parity_done_d = 1'b1;
    end else if (laf_state && low_pkt_valid_q && !parity_done_q) begin
      parity_done_d = 1'b1;
    end
  end

  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (detect_add) begin
      err_d = 1'b0;
    end else if (parity_done_q) begin
      err_d = (int_par_q != pkt_par_q);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout_q          <= '0;
      header_q        <= '0;
      full_q          <= '0;
      int_par_q       <= '0;
      pkt_par_q       <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      header_q        <= header_d;
      full_q          <= full_d;
      int_par_q       <= int_par_d;
      pkt_par_q       <= pkt_par_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

`ifdef ROUTER_REG_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counted on the cycle err rises so the count and the flag update together.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && !err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_router_data_reg.sv
// tb/tb_router_data_reg.sv - scoreboard bench for router_data_reg (expects err_count per ROUTER_REG_ERR_CNT_EN).
module tb_router_data_reg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DA   = 3'd1;
  localparam logic [2:0] LFD  = 3'd2;
  localparam logic [2:0] LD   = 3'd3;
  localparam logic [2:0] FULL = 3'd4;
  localparam logic [2:0] LAF  = 3'd5;
  localparam logic [2:0] CPE  = 3'd6;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full;
  logic [7:0] data_in;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // stimulus {state, pkt_valid, fifo_full, data_in}; expected {dout, parity_done, low_pkt_valid, err}
  logic [12:0] stim_q[$];
  logic [10:0] exp_q[$];

  router_data_reg #(.DATA_WIDTH(8), .ERR_CNT_W(8)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .full_state(full_state), .laf_state(laf_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic apply(input logic [12:0] s);
    detect_add  = (s[12:10] == DA);
    lfd_state   = (s[12:10] == LFD);
    ld_state    = (s[12:10] == LD);
    full_state  = (s[12:10] == FULL);
    laf_state   = (s[12:10] == LAF);
    rst_int_reg = (s[12:10] == CPE);
    pkt_valid   = s[9];
    fifo_full   = s[8];
    data_in     = s[7:0];
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    got = {dout, parity_done, low_pkt_valid, err};
    checks++;
    if (got !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", got, 11'h000);
    end
    checks++;
    if (err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_err_count: got %h want %h", err_count, 8'h00);
    end
  endtask

  task automatic test_good_packet();
    logic [12:0] s;
    logic [10:0] e, got;
    stim_q.push_back({DA,   2'b10, 8'h05}); exp_q.push_back({8'h00, 3'b000});
    stim_q.push_back({LFD,  2'b10, 8'h11}); exp_q.push_back({8'h05, 3'b000});
    stim_q.push_back({LD,   2'b10, 8'h11}); exp_q.push_back({8'h11, 3'b000});
    stim_q.push_back({LD,   2'b00, 8'h14}); exp_q.push_back({8'h14, 3'b110});
    stim_q.push_back({CPE,  2'b00, 8'h00}); exp_q.push_back({8'h14, 3'b100});
    stim_q.push_back({IDLE, 2'b00, 8'h00}); exp_q.push_back({8'h14, 3'b100});
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      e = exp_q.pop_front();
      got = {dout, parity_done, low_pkt_valid, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL good_packet step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_bad_parity();
    logic [12:0] s;
    logic [10:0] e, got;
    stim_q.push_back({DA,   2'b10, 8'h05}); exp_q.push_back({8'h14, 3'b000});
    stim_q.push_back({LFD,  2'b10, 8'h11}); exp_q.push_back({8'h05, 3'b000});
    stim_q.push_back({LD,   2'b10, 8'h11}); exp_q.push_back({8'h11, 3'b000});
    stim_q.push_back({LD,   2'b00, 8'h15}); exp_q.push_back({8'h15, 3'b110});
    stim_q.push_back({CPE,  2'b00, 8'h00}); exp_q.push_back({8'h15, 3'b101});
    stim_q.push_back({IDLE, 2'b00, 8'h00}); exp_q.push_back({8'h15, 3'b101});
    stim_q.push_back({DA,   2'b10, 8'h09}); exp_q.push_back({8'h15, 3'b000});
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      e = exp_q.pop_front();
      got = {dout, parity_done, low_pkt_valid, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL bad_parity step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  // Header 0x09 already latched by the previous task; parity 0x09^0x22^0xA5 = 0x8E.
  task automatic test_full_hold();
    logic [12:0] s;
    logic [10:0] e, got;
    stim_q.push_back({LFD,  2'b10, 8'h00}); exp_q.push_back({8'h09, 3'b000});
    stim_q.push_back({LD,   2'b10, 8'h22}); exp_q.push_back({8'h22, 3'b000});
    stim_q.push_back({LD,   2'b11, 8'hA5}); exp_q.push_back({8'h22, 3'b000});
    stim_q.push_back({FULL, 2'b11, 8'h00}); exp_q.push_back({8'h22, 3'b000});
    stim_q.push_back({LAF,  2'b10, 8'h00}); exp_q.push_back({8'hA5, 3'b000});
    stim_q.push_back({LD,   2'b00, 8'h8E}); exp_q.push_back({8'h8E, 3'b110});
    stim_q.push_back({CPE,  2'b00, 8'h00}); exp_q.push_back({8'h8E, 3'b100});
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      e = exp_q.pop_front();
      got = {dout, parity_done, low_pkt_valid, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL full_hold step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_parity_under_full();
    logic [12:0] s;
    logic [10:0] e, got;
    stim_q.push_back({DA,   2'b10, 8'h06}); exp_q.push_back({8'h8E, 3'b000});
    stim_q.push_back({LFD,  2'b10, 8'h00}); exp_q.push_back({8'h06, 3'b000});
    stim_q.push_back({LD,   2'b10, 8'h3A}); exp_q.push_back({8'h3A, 3'b000});
    stim_q.push_back({LD,   2'b01, 8'h3C}); exp_q.push_back({8'h3A, 3'b010});
    stim_q.push_back({FULL, 2'b01, 8'h00}); exp_q.push_back({8'h3A, 3'b010});
    stim_q.push_back({LAF,  2'b00, 8'h00}); exp_q.push_back({8'h3C, 3'b110});
    stim_q.push_back({CPE,  2'b00, 8'h00}); exp_q.push_back({8'h3C, 3'b100});
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      e = exp_q.pop_front();
      got = {dout, parity_done, low_pkt_valid, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL parity_under_full step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  // Header 0x07 must be ignored, so 0x06 is replayed and a zero-payload parity of 0x06 is good.
  task automatic test_addr3_header();
    logic [12:0] s;
    logic [10:0] e, got;
    stim_q.push_back({DA,  2'b10, 8'h07}); exp_q.push_back({8'h3C, 3'b000});
    stim_q.push_back({LFD, 2'b10, 8'h00}); exp_q.push_back({8'h06, 3'b000});
    stim_q.push_back({LD,  2'b00, 8'h06}); exp_q.push_back({8'h06, 3'b110});
    stim_q.push_back({CPE, 2'b00, 8'h00}); exp_q.push_back({8'h06, 3'b100});
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      e = exp_q.pop_front();
      got = {dout, parity_done, low_pkt_valid, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL addr3_header step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] s;
    logic [10:0] e, got;
    apply({DA,  2'b10, 8'h0D});
    apply({LFD, 2'b10, 8'h00});
    apply({LD,  2'b10, 8'h5A});
    checks++;
    if (dout !== 8'h5A) begin
      errors++;
      $display("FAIL async_reset_pre: got %h want %h", dout, 8'h5A);
    end
    #2 resetn = 1'b0;
    #1;
    got = {dout, parity_done, low_pkt_valid, err};
    checks++;
    if (got !== 11'h000 || err_count !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_clear: got %h cnt %h want 000 cnt 00", got, err_count);
    end
    {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = '0;
    #2 resetn = 1'b1;
    stim_q.push_back({DA,  2'b10, 8'h02}); exp_q.push_back({8'h00, 3'b000});
    stim_q.push_back({LFD, 2'b10, 8'h00}); exp_q.push_back({8'h02, 3'b000});
    stim_q.push_back({LD,  2'b10, 8'h00}); exp_q.push_back({8'h00, 3'b000});
    stim_q.push_back({LD,  2'b00, 8'h02}); exp_q.push_back({8'h02, 3'b110});
    stim_q.push_back({CPE, 2'b00, 8'h00}); exp_q.push_back({8'h02, 3'b100});
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      e = exp_q.pop_front();
      got = {dout, parity_done, low_pkt_valid, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL async_reset_packet step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  // Three back-to-back bad packets: header 0x01, payload 0xFF, parity 0x00 (true parity 0xFE).
  task automatic test_back_to_back_errors();
    logic [12:0] s;
    logic [10:0] e, got;
    logic [7:0]  prev;
    logic [7:0]  exp_cnt;
    prev = 8'h02;
    for (int p = 0; p < 3; p++) begin
      stim_q.push_back({DA,  2'b10, 8'h01}); exp_q.push_back({prev,  3'b000});
      stim_q.push_back({LFD, 2'b10, 8'h00}); exp_q.push_back({8'h01, 3'b000});
      stim_q.push_back({LD,  2'b10, 8'hFF}); exp_q.push_back({8'hFF, 3'b000});
      stim_q.push_back({LD,  2'b00, 8'h00}); exp_q.push_back({8'h00, 3'b110});
      stim_q.push_back({CPE, 2'b00, 8'h00}); exp_q.push_back({8'h00, 3'b101});
      prev = 8'h00;
    end
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      apply(s);
      e = exp_q.pop_front();
      got = {dout, parity_done, low_pkt_valid, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, got, e);
      end
    end
`ifdef ROUTER_REG_ERR_CNT_EN
    exp_cnt = 8'd3;
`else
    exp_cnt = 8'd0;
`endif
    checks++;
    if (err_count !== exp_cnt) begin
      errors++;
      $display("FAIL err_count: got %0d want %0d", err_count, exp_cnt);
    end
  endtask

  initial begin
    resetn = 1'b0;
    pkt_valid = 1'b0;
    fifo_full = 1'b0;
    data_in = 8'h00;
    {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = '0;
    #12;
    test_reset();
    resetn = 1'b1;
    test_good_packet();
    test_bad_parity();
    test_full_hold();
    test_parity_under_full();
    test_addr3_header();
    test_async_reset();
    test_back_to_back_errors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
